mac_inv_div: RTL

- Inverse of the MAC datapath: given a MAC result y plus the known operands a and c, recovers b = (y - c) / a.
- Sequential restoring divider, one quotient bit per cycle, with valid/ready handshakes on both sides.
- Sits downstream of the MAC stage; used to check and reconstruct operands from accumulated results.
- Flags divide-by-zero, underflow (y < c) and inexact results (non-zero remainder).

---
 rtl/mac_inv_div.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mac_inv_div.sv
// Recovers b = (y - c) / a from a MAC result by restoring division, one quotient bit per clk.
// Result after OUT_WIDTH+1 edges (error cases after one); holds q/r/flags until out_ready.
module mac_inv_div #(
   parameter int DATA_WIDTH = 4,
   parameter int OUT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OUT_WIDTH-1:0]  y,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] c,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  q,
   output logic [DATA_WIDTH-1:0] r,
   output logic                  div_zero,
   output logic                  underflow,
   output logic                  inexact
);

   localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         count, count_nxt;
   logic [OUT_WIDTH-1:0]  dividend, dividend_nxt;
   logic [DATA_WIDTH-1:0] divisor, divisor_nxt;
   logic [DATA_WIDTH:0]   partial, partial_nxt;
   logic [OUT_WIDTH-1:0]  q_nxt;
   logic [DATA_WIDTH-1:0] r_nxt;
   logic                  div_zero_nxt, underflow_nxt, inexact_nxt;

   logic [OUT_WIDTH:0]    diff;
   logic [DATA_WIDTH:0]   trial;
   logic                  fits;
   logic [DATA_WIDTH:0]   rem_step;
   logic [OUT_WIDTH-1:0]  shift_step;

   // diff[OUT_WIDTH] is the borrow of y - c, i.e. y < c
   assign diff = {1'b0, y} - {{(OUT_WIDTH + 1 - DATA_WIDTH){1'b0}}, c};

   assign trial      = {partial[DATA_WIDTH-1:0], dividend[OUT_WIDTH-1]};
   assign fits       = partial[DATA_WIDTH] | (trial >= {1'b0, divisor});
   assign rem_step   = fits ? (trial - {1'b0, divisor}) : trial;
   // quotient bits enter the dividend register as its bits leave, so it ends up holding q
   assign shift_step = {dividend[OUT_WIDTH-2:0], fits};

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      dividend_nxt  = dividend;
      divisor_nxt   = divisor;
      partial_nxt   = partial;
      q_nxt         = q;
      r_nxt         = r;
      div_zero_nxt  = div_zero;
      underflow_nxt = underflow;
      inexact_nxt   = inexact;
      case (state)
         IDLE: begin
            if (in_valid) begin
               dividend_nxt = diff[OUT_WIDTH-1:0];
               divisor_nxt  = a;
               if ((a == '0) || diff[OUT_WIDTH]) begin
                  state_nxt     = DONE;
                  div_zero_nxt  = (a == '0);
                  underflow_nxt = diff[OUT_WIDTH];
                  inexact_nxt   = 1'b0;
                  q_nxt         = '0;
                  r_nxt         = '0;
               end else begin
                  state_nxt     = DIV;
                  count_nxt     = CW'(OUT_WIDTH - 1);
                  partial_nxt   = '0;
                  div_zero_nxt  = 1'b0;
                  underflow_nxt = 1'b0;
                  inexact_nxt   = 1'b0;
               end
            end
         end
         DIV: begin
            dividend_nxt = shift_step;
            partial_nxt  = rem_step;
            if (count == '0) begin
               state_nxt   = DONE;
               q_nxt       = shift_step;
               r_nxt       = rem_step[DATA_WIDTH-1:0];
               inexact_nxt = |rem_step[DATA_WIDTH-1:0];
            end else begin
               count_nxt = count - CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         dividend  <= '0;
         divisor   <= '0;
         partial   <= '0;
         q         <= '0;
         r         <= '0;
         div_zero  <= 1'b0;
         underflow <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         dividend  <= dividend_nxt;
         divisor   <= divisor_nxt;
         partial   <= partial_nxt;
         q         <= q_nxt;
         r         <= r_nxt;
         div_zero  <= div_zero_nxt;
         underflow <= underflow_nxt;
         inexact   <= inexact_nxt;
      end
   end

endmodule
